// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the forward and inverse round datapaths:
//   - block width and round counts for AES-128/192/256
//   - encrypt FSM state type
//   - state-matrix byte indexing (column-major, byte 0 in bits [127:120])
//   - GF(2^8) helpers (xtime, gmul2, gmul3) and the MixColumns column function
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned NR_AES128   = 10;
    localparam int unsigned NR_AES192   = 12;
    localparam int unsigned NR_AES256   = 14;

    typedef enum logic {
        ST_IDLE,
        ST_ROUND
    } enc_state_e;

    // Byte number of s[row,col]; its bits sit at [AES_BLOCK_W-1-8*idx -: 8].
    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return 4 * col + row;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // One column through the {02,03,01,01} circulant; col[31:24] is row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
                a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Purely combinational AES forward S-box (counterpart of the inverse S-box).
// Ports:
//   in_byte  input  8  byte to substitute
//   out_byte output 8  S-box(in_byte)
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0x00 occupies the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n starts at bit 8*(255-n); 255-n is simply ~n for an 8-bit n.
    assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_round_core.sv
// -----------------------------------------------------------------------------
// aes_encrypt_round_core
// Iterative AES forward cipher: one full round (SubBytes, ShiftRows,
// MixColumns, AddRoundKey) per clock. Round keys are fetched from an external
// key store by index; no key expansion here.
// Ports:
//   clk        input   1    rising-edge clock
//   rst_n      input   1    asynchronous active-low reset
//   start      input   1    encrypt request, taken only while ready=1
//   plaintext  input   128  block to encrypt (byte 0 in [127:120], column-major)
//   ready      output  1    idle, can accept start
//   rk_idx     output  4    round-key index for the key store
//   rk         input   128  round key for rk_idx, same cycle
//   done       output  1    one-cycle pulse, ciphertext valid
//   ciphertext output  128  result, held until the next done
// -----------------------------------------------------------------------------
module aes_encrypt_round_core
    import aes_pkg::*;
#(
    parameter int unsigned NR = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AES_BLOCK_W-1:0] plaintext,
    output logic                   ready,
    output logic [3:0]             rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk,
    output logic                   done,
    output logic [AES_BLOCK_W-1:0] ciphertext
);

    if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
        $error("aes_encrypt_round_core: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    enc_state_e             fsm_q, fsm_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d;
    logic [3:0]             round_q, round_d;
    logic [AES_BLOCK_W-1:0] ct_q, ct_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;

    logic [AES_BLOCK_W-1:0] sb;
    logic [AES_BLOCK_W-1:0] sr;
    logic [AES_BLOCK_W-1:0] mc;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (blk_q[AES_BLOCK_W-1-8*i -: 8]),
            .out_byte (sb[AES_BLOCK_W-1-8*i -: 8])
        );
    end

    always_comb begin
        sr = '0;
        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[AES_BLOCK_W-1-8*byte_idx(r, c) -: 8] =
                    sb[AES_BLOCK_W-1-8*byte_idx(r, (c + r) % 4) -: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[AES_BLOCK_W-1-32*c -: 32] = mix_column(sr[AES_BLOCK_W-1-32*c -: 32]);
        end
    end

    // The round counter doubles as the key index: it is 0 whenever idle.
    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        round_d = round_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    blk_d   = plaintext ^ rk;
                    round_d = 4'd1;
                    ready_d = 1'b0;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_q == NR_L) begin
                    ct_d    = sr ^ rk;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    round_d = '0;
                    fsm_d   = ST_IDLE;
                end else begin
                    blk_d   = mc ^ rk;
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                round_d = '0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            blk_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            blk_q   <= blk_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign ciphertext = ct_q;
    assign rk_idx     = round_q;

endmodule
